// File: rtl/regfile_scoreboard.sv
// Parametrised register file with registered reads, write-through bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_INDEX = 29,
    parameter int SP_RESET = 252,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic              AnyPending
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    logic wr_en;
    logic rsv_en;
    logic byp1;
    logic byp2;

    assign wr_en  = RegWrite &&
                    !(ZERO_REG != 0 && WriteRegister == '0);
    assign rsv_en = Reserve &&
                    !(ZERO_REG != 0 && ReserveRegister == '0);

    assign byp1 = (BYPASS != 0) && wr_en &&
                  (WriteRegister == ReadRegister1);
    assign byp2 = (BYPASS != 0) && wr_en &&
                  (WriteRegister == ReadRegister2);

    // Reserve is applied after release: it belongs to a newer producer.
    always_comb begin
        pending_nxt = pending;
        if (wr_en)
            pending_nxt[WriteRegister] = 1'b0;
        if (rsv_en)
            pending_nxt[ReserveRegister] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            pending    <= '0;
            ReadData1  <= '0;
            ReadData2  <= '0;
            Busy1      <= 1'b0;
            Busy2      <= 1'b0;
            AnyPending <= 1'b0;
        end else begin
            if (wr_en)
                regs[WriteRegister] <= WriteData;
            pending    <= pending_nxt;
            ReadData1  <= byp1 ? WriteData : regs[ReadRegister1];
            ReadData2  <= byp2 ? WriteData : regs[ReadRegister2];
            Busy1      <= pending_nxt[ReadRegister1];
            Busy2      <= pending_nxt[ReadRegister2];
            AnyPending <= |pending_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard, with a BYPASS=0
// instance sharing the same stimulus.
module tb_regfile_scoreboard;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  rr1, rr2, wa, ra;
    logic [31:0] wd;
    logic        we, res;

    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        b1, b2, any;
    logic        nb_b1, nb_b2, nb_any;

    int vec_cnt = 0;
    int err_cnt = 0;

    regfile_scoreboard dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1), .ReadData2(rd2),
        .Busy1(b1), .Busy2(b2),
        .WriteRegister(wa), .WriteData(wd),
        .RegWrite(we), .Reserve(res),
        .ReserveRegister(ra), .AnyPending(any)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(nb_rd1), .ReadData2(nb_rd2),
        .Busy1(nb_b1), .Busy2(nb_b2),
        .WriteRegister(wa), .WriteData(wd),
        .RegWrite(we), .Reserve(res),
        .ReserveRegister(ra), .AnyPending(nb_any)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        res;
        logic [4:0]  ra;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_any;
        logic [31:0] e_nb_rd1;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s[%0d]: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_rd1", idx, rd1, 32'h0);
        chk("rst_rd2", idx, rd2, 32'h0);
        chk("rst_b1", idx, {31'h0, b1}, 32'h0);
        chk("rst_b2", idx, {31'h0, b2}, 32'h0);
        chk("rst_any", idx, {31'h0, any}, 32'h0);
        chk("rst_nb_rd1", idx, nb_rd1, 32'h0);
        chk("rst_nb_any", idx, {31'h0, nb_any}, 32'h0);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        rr1 = a1; rr2 = a2;
        we = 0; wa = 0; wd = 0;
        res = 0; ra = 0;
    endtask

    initial begin
        // rr1 rr2 we wa wd res ra | rd1 rd2 b1 b2 any nb_rd1
        vec[0]  = '{29, 5, 0, 0, 0, 0, 0,
                    252, 0, 0, 0, 0, 252};
        vec[1]  = '{8, 8, 1, 8, 32'hDEADBEEF, 0, 0,
                    32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0};
        vec[2]  = '{8, 29, 0, 0, 0, 0, 0,
                    32'hDEADBEEF, 252, 0, 0, 0, 32'hDEADBEEF};
        vec[3]  = '{0, 0, 1, 0, 32'h12345678, 1, 0,
                    0, 0, 0, 0, 0, 0};
        vec[4]  = '{10, 0, 0, 0, 0, 1, 10,
                    0, 0, 1, 0, 1, 0};
        vec[5]  = '{10, 10, 0, 0, 0, 0, 0,
                    0, 0, 1, 1, 1, 0};
        vec[6]  = '{10, 0, 0, 0, 0, 1, 10,
                    0, 0, 1, 0, 1, 0};
        vec[7]  = '{10, 8, 1, 10, 32'h55, 0, 0,
                    32'h55, 32'hDEADBEEF, 0, 0, 0, 0};
        vec[8]  = '{12, 12, 1, 12, 32'hA5A5A5A5, 1, 12,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1, 1, 0};
        vec[9]  = '{12, 10, 0, 0, 0, 0, 0,
                    32'hA5A5A5A5, 32'h55, 1, 0, 1, 32'hA5A5A5A5};
        vec[10] = '{12, 29, 1, 12, 32'h1, 0, 0,
                    32'h1, 252, 0, 0, 0, 32'hA5A5A5A5};
        vec[11] = '{29, 29, 1, 29, 32'h100, 0, 0,
                    32'h100, 32'h100, 0, 0, 0, 252};
        vec[12] = '{3, 5, 1, 5, 32'h7, 1, 3,
                    0, 32'h7, 1, 0, 1, 0};
        vec[13] = '{3, 5, 1, 3, 32'h9, 0, 0,
                    32'h9, 32'h7, 0, 0, 0, 0};
        vec[14] = '{10, 8, 0, 0, 0, 1, 10,
                    32'h55, 32'hDEADBEEF, 1, 0, 1, 32'h55};

        Rst_n = 1'b0;
        idle(0, 0);
        #3;
        chk_all_zero(-1);
        #9;
        Rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            rr1 = vec[i].rr1; rr2 = vec[i].rr2;
            we  = vec[i].we;  wa  = vec[i].wa;
            wd  = vec[i].wd;
            res = vec[i].res; ra  = vec[i].ra;
            @(posedge Clk);
            #1;
            chk("rd1", i, rd1, vec[i].e_rd1);
            chk("rd2", i, rd2, vec[i].e_rd2);
            chk("busy1", i, {31'h0, b1}, {31'h0, vec[i].e_b1});
            chk("busy2", i, {31'h0, b2}, {31'h0, vec[i].e_b2});
            chk("any", i, {31'h0, any}, {31'h0, vec[i].e_any});
            chk("nb_rd1", i, nb_rd1, vec[i].e_nb_rd1);
        end

        // Asynchronous reset between edges, with state populated.
        idle(8, 29);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_all_zero(100);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rd1", 101, rd1, 32'h0);
        chk("post_rd2", 101, rd2, 32'd252);
        chk("post_any", 101, {31'h0, any}, 32'h0);
        chk("post_nb_rd2", 101, nb_rd2, 32'd252);

        idle(10, 10);
        @(posedge Clk);
        #1;
        chk("post_rd10", 102, rd1, 32'h0);
        chk("post_b1", 102, {31'h0, b1}, 32'h0);
        chk("post_b2", 102, {31'h0, b2}, 32'h0);
        chk("post_nb_b1", 102, {31'h0, nb_b1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
